data_mem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory request interface.
- Accepts one read or write request at a time from the MEM stage and models a multi-cycle synchronous data RAM.
- Applies big-endian byte/halfword store lanes and returns the full aligned word on reads; the MEM stage performs load alignment.
- Drives a stall/ready handshake so the pipeline freezes until the access completes.

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one request at a
// time, applies big-endian store lanes, returns full aligned words on reads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] data_address,
  input  logic [31:0] data_write,
  input  logic [1:0]  store_size,
  output logic [31:0] data_read,
  output logic        mem_ready,
  output logic        mem_stall,
  output logic        addr_error
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [31:0]       data_read_q;
  logic              mem_ready_q;
  logic              addr_error_q;

  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              rd_q;
  logic              wr_q;

  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              commit;
  logic              mem_we;

  // Big-endian lane merge: byte offset 0 lives in bits 31:24.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] w;
    w = old_w;
    case (sz)
      2'b00: begin
        case (off)
          2'b00:   w[31:24] = wd[7:0];
          2'b01:   w[23:16] = wd[7:0];
          2'b10:   w[15:8]  = wd[7:0];
          default: w[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) w[15:0]  = wd[15:0];
        else        w[31:16] = wd[15:0];
      end
      default: w = wd;
    endcase
    return w;
  endfunction

  assign idx = addr_q[ADDR_W+1:2];

  // Alignment and size rules apply only to stores; reads ignore size and offset.
  always_comb begin
    fault = 1'b0;
    if (rd_q && wr_q) fault = 1'b1;
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) fault = 1'b1;
    if (wr_q && !rd_q) begin
      case (size_q)
        2'b01:   if (addr_q[0]) fault = 1'b1;
        2'b10:   if (addr_q[1:0] != 2'b00) fault = 1'b1;
        2'b11:   fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // RESET gates the write so an access abandoned at its commit edge never lands.
  assign mem_we = commit && wr_q && !rd_q && !fault && !RESET;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      data_read_q  <= 32'd0;
      mem_ready_q  <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_ready_q <= 1'b0;
          if (MemRead || MemWrite) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q      <= S_RESP;
            mem_ready_q  <= 1'b1;
            addr_error_q <= fault;
            if (fault)     data_read_q <= 32'd0;
            else if (rd_q) data_read_q <= mem[idx];
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          mem_ready_q  <= 1'b0;
          addr_error_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Request capture: data-only registers, loaded on acceptance.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && (MemRead || MemWrite)) begin
      addr_q  <= data_address;
      wdata_q <= data_write;
      size_q  <= store_size;
      rd_q    <= MemRead;
      wr_q    <= MemWrite;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx] <= store_merge(mem[idx], wdata_q, size_q, addr_q[1:0]);
  end

  assign data_read  = data_read_q;
  assign mem_ready  = mem_ready_q;
  assign addr_error = addr_error_q;
  assign mem_stall  = (MemRead | MemWrite) & ~mem_ready_q & ~RESET;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, multi-cycle corner
// sequences, and a randomized run against a byte-addressed reference model.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;

  logic        CLK;
  logic        RESET;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] data_address;
  logic [31:0] data_write;
  logic [1:0]  store_size;
  logic [31:0] data_read;
  logic        mem_ready;
  logic        mem_stall;
  logic        addr_error;

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .CLK(CLK), .RESET(RESET), .MemRead(MemRead), .MemWrite(MemWrite),
    .data_address(data_address), .data_write(data_write), .store_size(store_size),
    .data_read(data_read), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .addr_error(addr_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs[$];

  // Reference model: byte-addressed big-endian memory plus the last read value.
  logic [7:0]  mb [DEPTH_WORDS*4];
  logic [31:0] m_dr;

  function automatic vec_t mk(input string n, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] sz, input logic [31:0] ed,
                              input logic ee);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.sz = sz;
    v.exp_d = ed; v.exp_e = ee;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic model_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz,
                          output logic [31:0] ed, output logic ee);
    bit f;
    int unsigned base;
    f = (rd && wr) || ((a >> 2) >= 32'(DEPTH_WORDS));
    if (wr && !rd) begin
      if (sz == 2'd3) f = 1;
      if (sz == 2'd1 && a[0]) f = 1;
      if (sz == 2'd2 && a[1:0] != 2'd0) f = 1;
    end
    base = a & 32'hFFFF_FFFC;
    if (f) begin
      m_dr = 32'd0;
    end else if (rd) begin
      m_dr = {mb[base], mb[base+1], mb[base+2], mb[base+3]};
    end else begin
      case (sz)
        2'd0: mb[a] = wd[7:0];
        2'd1: begin mb[a] = wd[15:8]; mb[a+1] = wd[7:0]; end
        default: begin
          mb[base] = wd[31:24]; mb[base+1] = wd[23:16];
          mb[base+2] = wd[15:8]; mb[base+3] = wd[7:0];
        end
      endcase
    end
    ed = m_dr;
    ee = f;
  endtask

  // Presents a request at a falling edge and holds it until mem_ready is seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz,
                        output logic [31:0] d, output logic e,
                        output int s, output int r, output bit sok);
    @(negedge CLK);
    MemRead = rd; MemWrite = wr; data_address = a; data_write = wd; store_size = sz;
    s = cyc; r = -1; d = '0; e = 1'b0; sok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_ready === 1'b1) begin
        r = cyc; d = data_read; e = addr_error;
        if (mem_stall !== 1'b0) sok = 1'b0;
        break;
      end
      if (mem_stall !== 1'b1) sok = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic run_vec(input string nm, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         input logic [31:0] ed, input logic ee, input bit chk_d);
    logic [31:0] d;
    logic        e;
    int          s, r;
    bit          sok;
    access(rd, wr, a, wd, sz, d, e, s, r, sok);
    check({nm, ".lat"}, 32'(r - s), 32'(LATENCY + 1));
    check({nm, ".stall"}, 32'(sok), 32'd1);
    check({nm, ".err"}, 32'(e), 32'(ee));
    if (chk_d) check({nm, ".data"}, d, ed);
  endtask

  task automatic idle_chk(input string nm, input int n);
    int bad;
    bad = 0;
    @(negedge CLK);
    MemRead = 1'b0; MemWrite = 1'b0;
    for (int c = 0; c < n; c++) begin
      #1;
      if (mem_ready !== 1'b0 || mem_stall !== 1'b0) bad++;
      @(negedge CLK);
    end
    check(nm, 32'(bad), 32'd0);
  endtask

  logic [31:0] d1, d2, ed, a;
  logic        e1, e2, ee, rd, wr;
  logic [31:0] wd;
  logic [1:0]  sz;
  int          s1, r1, s2, r2, kind;
  bit          ok1, ok2;

  initial begin
    checks = 0; failures = 0;
    RESET = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    data_address = '0; data_write = '0; store_size = '0;
    #3;
    check("rst.stall", 32'(mem_stall), 32'd0);
    check("rst.ready", 32'(mem_ready), 32'd0);
    check("rst.err", 32'(addr_error), 32'd0);
    check("rst.data", data_read, 32'd0);
    @(negedge CLK); MemRead = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    idle_chk("rst.idle", 5);

    vecs.push_back(mk("w40",    0, 1, 32'h40,  32'hDEADBEEF, 2'd2, 32'h0,        0));
    vecs.push_back(mk("r40",    1, 0, 32'h40,  32'h0,        2'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk("w80",    0, 1, 32'h80,  32'h11223344, 2'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk("sb81",   0, 1, 32'h81,  32'h000000AA, 2'd0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("r80a",   1, 0, 32'h80,  32'h0,        2'd2, 32'h11AA3344, 0));
    vecs.push_back(mk("sh82",   0, 1, 32'h82,  32'h0000BBCC, 2'd1, 32'h11AA3344, 0));
    vecs.push_back(mk("r80b",   1, 0, 32'h80,  32'h0,        2'd2, 32'h11AABBCC, 0));
    vecs.push_back(mk("sh83",   0, 1, 32'h83,  32'h00001234, 2'd1, 32'h0,        1));
    vecs.push_back(mk("r80c",   1, 0, 32'h80,  32'h0,        2'd2, 32'h11AABBCC, 0));
    vecs.push_back(mk("roob",   1, 0, 32'h1000, 32'h0,       2'd2, 32'h0,        1));
    vecs.push_back(mk("r40b",   1, 0, 32'h40,  32'h0,        2'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk("both",   1, 1, 32'h80,  32'hFFFFFFFF, 2'd2, 32'h0,        1));
    vecs.push_back(mk("r80d",   1, 0, 32'h80,  32'h0,        2'd2, 32'h11AABBCC, 0));
    vecs.push_back(mk("wmis",   0, 1, 32'h42,  32'hCAFEF00D, 2'd2, 32'h0,        1));
    vecs.push_back(mk("wsz3",   0, 1, 32'h40,  32'hCAFEF00D, 2'd3, 32'h0,        1));
    vecs.push_back(mk("r40c",   1, 0, 32'h40,  32'h0,        2'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk("w44",    0, 1, 32'h44,  32'h12345678, 2'd2, 32'hDEADBEEF, 0));
    vecs.push_back(mk("r47h",   1, 0, 32'h47,  32'h0,        2'd1, 32'h12345678, 0));
    vecs.push_back(mk("sb44",   0, 1, 32'h44,  32'h000000EE, 2'd0, 32'h12345678, 0));
    vecs.push_back(mk("sb47",   0, 1, 32'h47,  32'h00000011, 2'd0, 32'h12345678, 0));
    vecs.push_back(mk("r44a",   1, 0, 32'h44,  32'h0,        2'd2, 32'hEE345611, 0));
    vecs.push_back(mk("sh44",   0, 1, 32'h44,  32'h00009876, 2'd1, 32'hEE345611, 0));
    vecs.push_back(mk("r44b",   1, 0, 32'h44,  32'h0,        2'd2, 32'h98765611, 0));
    vecs.push_back(mk("wtop",   0, 1, 32'hFFC, 32'hA5A5A5A5, 2'd2, 32'h98765611, 0));
    vecs.push_back(mk("rtop",   1, 0, 32'hFFC, 32'h0,        2'd2, 32'hA5A5A5A5, 0));
    vecs.push_back(mk("rhigh",  1, 0, 32'hFFFFFFFC, 32'h0,   2'd2, 32'h0,        1));
    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
              vecs[i].sz, vecs[i].exp_d, vecs[i].exp_e, 1'b1);

    // Back-to-back: first request held through RESP, second presented right after.
    access(1'b1, 1'b0, 32'h80, 32'h0, 2'd2, d1, e1, s1, r1, ok1);
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, d2, e2, s2, r2, ok2);
    check("b2b.first", 32'(r1 - s1), 32'(LATENCY + 1));
    check("b2b.start2", 32'(s2 - s1), 32'(LATENCY + 2));
    check("b2b.second", 32'(r2 - s1), 32'(2 * LATENCY + 3));
    check("b2b.d1", d1, 32'h11AABBCC);
    check("b2b.d2", d2, 32'hDEADBEEF);
    idle_chk("b2b.nodouble", 8);

    // Reset while a write to 0x40 sits in WAIT.
    run_vec("pre5", 1'b0, 1'b1, 32'h40, 32'h5, 2'd2, 32'h0, 1'b0, 1'b0);
    @(negedge CLK);
    MemRead = 1'b0; MemWrite = 1'b1; data_address = 32'h40;
    data_write = 32'h77777777; store_size = 2'd2;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rmid.stall", 32'(mem_stall), 32'd0);
    MemWrite = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      #1;
      check("rmid.noready", 32'(mem_ready), 32'd0);
    end
    RESET = 1'b0;
    check("rmid.data", data_read, 32'd0);
    idle_chk("rmid.idle", 6);
    run_vec("rmid.r40", 1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 32'h5, 1'b0, 1'b1);

    // Randomized phase over a 16-word window, after seeding it with word writes.
    m_dr = 32'h5;
    for (int w = 0; w < 16; w++) begin
      a = 32'h200 + 32'(4 * w);
      wd = $urandom;
      model_op(1'b0, 1'b1, a, wd, 2'd2, ed, ee);
      run_vec($sformatf("init%0d", w), 1'b0, 1'b1, a, wd, 2'd2, ed, ee, 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      wr = ~rd;
      a = 32'h200 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (kind == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (kind == 1) begin
        a = 32'h8000_0000 | $urandom;
      end
      model_op(rd, wr, a, wd, sz, ed, ee);
      run_vec($sformatf("rnd%0d", i), rd, wr, a, wd, sz, ed, ee, 1'b1);
    end
    idle_chk("rnd.idle", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
